mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255, is the bus-wait cycle limit; it is used only when MEM_ARB_TIMEOUT_EN is defined.
REQ-002 clk  input  1  CPU clock; all state updates on its rising edge.
REQ-003 rstn  input  1  reset, asynchronous and active-low.
REQ-004 if_req, if_addr  input  1/32  instruction-fetch request and its word address.
REQ-005 if_ack, if_rdata  output  1/32  fetch-completion pulse and its fetched word.
REQ-006 mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb  input  1/1/32/32/4  data-access request, write enable, address, write data and byte strobes.
REQ-007 mem_ack, mem_rdata  output  1/32  data-access completion pulse and its load word.
REQ-008 flush  input  1  pipeline flush; suppresses any pending fetch completion.
REQ-009 bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb  output  1/1/32/32/4  request to the single shared memory port.
REQ-010 bus_rdata, bus_ready  input  32/1  shared-port read data and completion strobe.
REQ-011 stall_if, stall_mem  output  1/1  stall requests to the pipeline controller.
REQ-012 err_timeout  output  1  sticky bus-timeout flag.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, IF_BUSY, MEM_BUSY and DONE.
REQ-014 In IDLE with mem_req=1, the FSM SHALL enter MEM_BUSY, except when the previous grant was MEM and if_req=1, in which case it SHALL enter IF_BUSY.
REQ-015 In IDLE with only if_req=1, the FSM SHALL enter IF_BUSY; with no request it SHALL stay in IDLE.
REQ-016 On each grant, the block SHALL register the address, we, wdata and wstrb; a fetch grant SHALL force bus_we=0 and bus_wstrb=0.
REQ-017 bus_req SHALL be 1 exactly while in IF_BUSY or MEM_BUSY, and the bus_* outputs SHALL stay stable throughout that time.
REQ-018 bus_ready=1 in a BUSY state SHALL register bus_rdata into the granted requester's rdata output and move the FSM to DONE.
REQ-019 bus_ready SHALL be ignored in IDLE and DONE.
REQ-020 DONE SHALL last exactly one cycle, SHALL pulse the granted requester's ack for that cycle, SHALL take no new grant, and SHALL then return to IDLE.
REQ-021 Latency: a request sampled in IDLE at cycle N SHALL drive bus_req from N+1; bus_ready at cycle M SHALL give ack and valid rdata at M+1.
REQ-022 With bus_ready tied 1, the minimum fetch-to-ack time SHALL be 2 cycles.
REQ-023 Requesters hold req and payload stable until ack and drop req in the cycle after ack.
REQ-024 stall_if SHALL equal if_req & ~if_ack, and stall_mem SHALL equal mem_req & ~mem_ack; both are combinational.
REQ-025 flush=1 during IF_BUSY, or on the edge entering DONE for a fetch, SHALL let the bus transaction complete and SHALL suppress if_ack for it.
REQ-026 flush SHALL have no effect on data accesses.
REQ-027 rdata outputs SHALL hold their last value until the next completion for the same requester.

Reset
REQ-028 rstn=0 SHALL immediately force: state IDLE, last grant IF, bus_req 0, bus_we 0, bus_addr/wdata 0, bus_wstrb 0, both acks 0, both rdata 0, err_timeout 0, wait counter 0.
REQ-029 A reset in mid-transaction SHALL abandon the transaction, and a late bus_ready after reset SHALL be ignored.

Configuration
REQ-030 With MEM_ARB_TIMEOUT_EN defined, an 8-bit wait counter SHALL run in each BUSY state; reaching TIMEOUT_CYC without bus_ready SHALL drop bus_req, go to DONE, ack with rdata 0, and set err_timeout sticky until reset.
REQ-031 Without MEM_ARB_TIMEOUT_EN, the counter logic SHALL be absent, err_timeout SHALL be constant 0, and a BUSY state SHALL wait indefinitely.

Verification
REQ-032 Fetch read: if_req=1, if_addr=0x100, bus_ready asserted 3 cycles after bus_req with bus_rdata=0x00000013 -> if_ack 1-cycle pulse, if_rdata=0x00000013, stall_if high until the ack cycle.
REQ-033 Contention: if_req and mem_req both 1 from reset -> grant order MEM, IF, MEM, IF while both stay pending.
REQ-034 Store: mem_we=1, mem_addr=0x2000, mem_wdata=0xCAFEBABE, mem_wstrb=0x3 -> bus_we=1, bus_wstrb=0x3 and stable payload until bus_ready, then mem_ack pulse.
REQ-035 Flush: pulse flush during IF_BUSY -> bus completes and if_ack stays 0; the next fetch is granted normally.
REQ-036 Timeout (macro on, TIMEOUT_CYC=4): bus_ready never asserted -> bus_req drops after 4 cycles, ack with rdata 0, err_timeout=1 and held; rstn low clears it.
REQ-037 Reset mid-BUSY: rstn low for 1 cycle, then bus_ready=1 -> no ack, state IDLE, all outputs 0.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data-access and shared-memory-port signals around mem_port_arbiter.
// master = arbiter side, slave = pipeline/memory side.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic        flush;

    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_rdata;
    logic        bus_ready;

    logic        stall_if;
    logic        stall_mem;
    logic        err_timeout;

    modport master (
        input  if_req, if_addr,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  flush,
        input  bus_rdata, bus_ready,
        output if_ack, if_rdata,
        output mem_ack, mem_rdata,
        output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
        output stall_if, stall_mem, err_timeout
    );

    modport slave (
        output if_req, if_addr,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output flush,
        output bus_rdata, bus_ready,
        input  if_ack, if_rdata,
        input  mem_ack, mem_rdata,
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
        input  stall_if, stall_mem, err_timeout
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one memory port between instruction fetch and data access (MEM_ARB_TIMEOUT_EN adds a bounded bus wait).
// Latency: bus_req one cycle after a request is sampled in IDLE; ack and rdata one cycle after bus_ready.
// Backpressure: requesters hold req until ack; stall_if/stall_mem stay high while a request is unacknowledged.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic               clk,
    input  logic               rstn,
    mem_port_arbiter_if.master port
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IF_BUSY  = 2'd1,
        MEM_BUSY = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        last_mem_q;
    logic        flush_seen_q;
    logic        bus_we_q;
    logic [31:0] bus_addr_q;
    logic [31:0] bus_wdata_q;
    logic [3:0]  bus_wstrb_q;
    logic        if_ack_q;
    logic        mem_ack_q;
    logic [31:0] if_rdata_q;
    logic [31:0] mem_rdata_q;
    logic        err_q;

    logic        busy;
    logic        grant_if;
    logic        grant_mem;
    logic        complete;
    logic        timeout_hit;
    logic        if_kill;
    logic [31:0] done_data;

    assign busy      = (state_q == IF_BUSY) || (state_q == MEM_BUSY);
    // A flush seen at any point of the fetch, including its completing edge, drops the ack.
    assign if_kill   = flush_seen_q || port.flush;
    assign done_data = port.bus_ready ? port.bus_rdata : 32'h0;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 1);

    logic [7:0] wait_cnt_q;

    assign timeout_hit = busy && !port.bus_ready && (wait_cnt_q == WAIT_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wait_cnt_q <= 8'h0;
            err_q      <= 1'b0;
        end else begin
            wait_cnt_q <= busy ? wait_cnt_q + 8'd1 : 8'h0;
            if (timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err_q       = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        grant_if  = 1'b0;
        grant_mem = 1'b0;
        complete  = 1'b0;
        case (state_q)
            IDLE: begin
                // Data wins unless it also won last time and a fetch is waiting.
                if (port.mem_req && !(last_mem_q && port.if_req)) begin
                    state_d   = MEM_BUSY;
                    grant_mem = 1'b1;
                end else if (port.if_req) begin
                    state_d  = IF_BUSY;
                    grant_if = 1'b1;
                end
            end
            IF_BUSY, MEM_BUSY: begin
                if (port.bus_ready || timeout_hit) begin
                    state_d  = DONE;
                    complete = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            last_mem_q   <= 1'b0;
            flush_seen_q <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= 32'h0;
            bus_wdata_q  <= 32'h0;
            bus_wstrb_q  <= 4'h0;
            if_ack_q     <= 1'b0;
            mem_ack_q    <= 1'b0;
            if_rdata_q   <= 32'h0;
            mem_rdata_q  <= 32'h0;
        end else begin
            state_q   <= state_d;
            if_ack_q  <= complete && !last_mem_q && !if_kill;
            mem_ack_q <= complete && last_mem_q;

            if (grant_mem) begin
                last_mem_q  <= 1'b1;
                bus_we_q    <= port.mem_we;
                bus_addr_q  <= port.mem_addr;
                bus_wdata_q <= port.mem_wdata;
                bus_wstrb_q <= port.mem_wstrb;
            end else if (grant_if) begin
                last_mem_q  <= 1'b0;
                bus_we_q    <= 1'b0;
                bus_addr_q  <= port.if_addr;
                bus_wdata_q <= 32'h0;
                bus_wstrb_q <= 4'h0;
            end

            if (grant_if) begin
                flush_seen_q <= 1'b0;
            end else if ((state_q == IF_BUSY) && port.flush) begin
                flush_seen_q <= 1'b1;
            end

            if (complete && last_mem_q) begin
                mem_rdata_q <= done_data;
            end
            if (complete && !last_mem_q && !if_kill) begin
                if_rdata_q <= done_data;
            end
        end
    end

    assign port.bus_req     = busy;
    assign port.bus_we      = bus_we_q;
    assign port.bus_addr    = bus_addr_q;
    assign port.bus_wdata   = bus_wdata_q;
    assign port.bus_wstrb   = bus_wstrb_q;
    assign port.if_ack      = if_ack_q;
    assign port.if_rdata    = if_rdata_q;
    assign port.mem_ack     = mem_ack_q;
    assign port.mem_rdata   = mem_rdata_q;
    assign port.stall_if    = port.if_req & ~if_ack_q;
    assign port.stall_mem   = port.mem_req & ~mem_ack_q;
    assign port.err_timeout = err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run against a transaction-level model.
// Build with MEM_ARB_TIMEOUT_EN defined to exercise the timeout path (TIMEOUT_CYC=4 here).
module tb_mem_port_arbiter;
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if bus_if ();

    mem_port_arbiter #(.TIMEOUT_CYC(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .port (bus_if.master)
    );

    function automatic logic [136:0] all_outs();
        return {bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wdata, bus_if.bus_wstrb,
                bus_if.if_ack, bus_if.mem_ack, bus_if.if_rdata, bus_if.mem_rdata, bus_if.err_timeout};
    endfunction

    function automatic logic [69:0] bus_vec();
        return {bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wdata, bus_if.bus_wstrb};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus_if.if_req    = 1'b0;
        bus_if.if_addr   = 32'h0;
        bus_if.mem_req   = 1'b0;
        bus_if.mem_we    = 1'b0;
        bus_if.mem_addr  = 32'h0;
        bus_if.mem_wdata = 32'h0;
        bus_if.mem_wstrb = 4'h0;
        bus_if.flush     = 1'b0;
        bus_if.bus_rdata = 32'h0;
        bus_if.bus_ready = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rstn = 1'b0;
        bus_if.if_req    = 1'b1;
        bus_if.bus_ready = 1'b1;
        bus_if.bus_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        total++;
        if (all_outs() !== 137'h0) begin
            bad++;
            $display("FAIL reset_outs got=%h exp=0", all_outs());
        end
        total++;
        if (bus_if.stall_if !== 1'b1) begin
            bad++;
            $display("FAIL reset_stall_if got=%b exp=1", bus_if.stall_if);
        end
        @(negedge clk);
        total++;
        if (bus_if.bus_req !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold_bus_req got=%b exp=0", bus_if.bus_req);
        end
        clear_inputs();
    endtask

    task automatic test_fetch();
        do_reset();
        bus_if.if_req  = 1'b1;
        bus_if.if_addr = 32'h100;
        @(negedge clk);
        total++;
        if ({bus_if.bus_req, bus_if.stall_if} !== 2'b01) begin
            bad++;
            $display("FAIL fetch_idle got=%b exp=01", {bus_if.bus_req, bus_if.stall_if});
        end
        tick();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if ({bus_vec(), bus_if.stall_if, bus_if.if_ack} !== {1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 1'b1, 1'b0}) begin
                bad++;
                $display("FAIL fetch_wait c=%0d got=%h exp=%h", c, {bus_vec(), bus_if.stall_if, bus_if.if_ack},
                         {1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 1'b1, 1'b0});
            end
            tick();
        end
        bus_if.bus_ready = 1'b1;
        bus_if.bus_rdata = 32'h0000_0013;
        tick();
        bus_if.bus_ready = 1'b0;
        @(negedge clk);
        total++;
        if ({bus_if.bus_req, bus_if.if_ack, bus_if.stall_if, bus_if.if_rdata} !== {1'b0, 1'b1, 1'b0, 32'h13}) begin
            bad++;
            $display("FAIL fetch_ack got=%h exp=%h", {bus_if.bus_req, bus_if.if_ack, bus_if.stall_if, bus_if.if_rdata},
                     {1'b0, 1'b1, 1'b0, 32'h13});
        end
        tick();
        bus_if.if_req = 1'b0;
        @(negedge clk);
        total++;
        if ({bus_if.if_ack, bus_if.if_rdata} !== {1'b0, 32'h13}) begin
            bad++;
            $display("FAIL fetch_pulse_end got=%h exp=%h", {bus_if.if_ack, bus_if.if_rdata}, {1'b0, 32'h13});
        end
    endtask

    task automatic test_contention();
        logic exp_mem [4];
        logic got_mem [4];
        int   n;
        exp_mem = '{1'b1, 1'b0, 1'b1, 1'b0};
        n = 0;
        do_reset();
        bus_if.if_req    = 1'b1;
        bus_if.if_addr   = 32'hA0;
        bus_if.mem_req   = 1'b1;
        bus_if.mem_addr  = 32'hB0;
        bus_if.bus_ready = 1'b1;
        for (int c = 0; c < 20 && n < 4; c++) begin
            @(negedge clk);
            if (bus_if.bus_req) begin
                got_mem[n] = (bus_if.bus_addr == 32'hB0);
                n++;
            end
        end
        total++;
        if (n != 4) begin
            bad++;
            $display("FAIL contention_count got=%0d exp=4", n);
        end
        for (int i = 0; i < n; i++) begin
            total++;
            if (got_mem[i] !== exp_mem[i]) begin
                bad++;
                $display("FAIL contention_order i=%0d got_mem=%b exp_mem=%b", i, got_mem[i], exp_mem[i]);
            end
        end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_store();
        do_reset();
        bus_if.mem_req   = 1'b1;
        bus_if.mem_we    = 1'b1;
        bus_if.mem_addr  = 32'h2000;
        bus_if.mem_wdata = 32'hCAFE_BABE;
        bus_if.mem_wstrb = 4'h3;
        tick();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if ({bus_vec(), bus_if.stall_mem, bus_if.mem_ack} !== {1'b1, 1'b1, 32'h2000, 32'hCAFE_BABE, 4'h3, 1'b1, 1'b0}) begin
                bad++;
                $display("FAIL store_payload c=%0d got=%h exp=%h", c, {bus_vec(), bus_if.stall_mem, bus_if.mem_ack},
                         {1'b1, 1'b1, 32'h2000, 32'hCAFE_BABE, 4'h3, 1'b1, 1'b0});
            end
            if (c < 2) tick();
        end
        bus_if.bus_ready = 1'b1;
        tick();
        bus_if.bus_ready = 1'b0;
        @(negedge clk);
        total++;
        if ({bus_if.bus_req, bus_if.mem_ack, bus_if.if_ack, bus_if.stall_mem} !== 4'b0100) begin
            bad++;
            $display("FAIL store_ack got=%b exp=0100", {bus_if.bus_req, bus_if.mem_ack, bus_if.if_ack, bus_if.stall_mem});
        end
        tick();
        bus_if.mem_req = 1'b0;
        @(negedge clk);
        total++;
        if (bus_if.mem_ack !== 1'b0) begin
            bad++;
            $display("FAIL store_pulse_end got=%b exp=0", bus_if.mem_ack);
        end
    endtask

    task automatic test_flush();
        do_reset();
        bus_if.if_req  = 1'b1;
        bus_if.if_addr = 32'h200;
        tick();
        bus_if.flush = 1'b1;
        tick();
        bus_if.flush = 1'b0;
        @(negedge clk);
        total++;
        if (bus_if.bus_req !== 1'b1) begin
            bad++;
            $display("FAIL flush_bus_holds got=%b exp=1", bus_if.bus_req);
        end
        bus_if.bus_ready = 1'b1;
        bus_if.bus_rdata = 32'h55;
        tick();
        bus_if.bus_ready = 1'b0;
        bus_if.if_addr   = 32'h300;
        @(negedge clk);
        total++;
        if ({bus_if.bus_req, bus_if.if_ack} !== 2'b00) begin
            bad++;
            $display("FAIL flush_suppress got=%b exp=00", {bus_if.bus_req, bus_if.if_ack});
        end
        tick();
        @(negedge clk);
        total++;
        if ({bus_if.bus_req, bus_if.if_ack} !== 2'b00) begin
            bad++;
            $display("FAIL flush_no_late_ack got=%b exp=00", {bus_if.bus_req, bus_if.if_ack});
        end
        tick();
        @(negedge clk);
        total++;
        if (bus_vec() !== {1'b1, 1'b0, 32'h300, 32'h0, 4'h0}) begin
            bad++;
            $display("FAIL flush_next_grant got=%h exp=%h", bus_vec(), {1'b1, 1'b0, 32'h300, 32'h0, 4'h0});
        end
        bus_if.bus_ready = 1'b1;
        bus_if.bus_rdata = 32'h77;
        tick();
        bus_if.bus_ready = 1'b0;
        @(negedge clk);
        total++;
        if ({bus_if.if_ack, bus_if.if_rdata} !== {1'b1, 32'h77}) begin
            bad++;
            $display("FAIL flush_next_ack got=%h exp=%h", {bus_if.if_ack, bus_if.if_rdata}, {1'b1, 32'h77});
        end
        tick();
        bus_if.if_req = 1'b0;
        tick();
        // flush arriving on the very edge that completes the fetch
        bus_if.if_req  = 1'b1;
        bus_if.if_addr = 32'h400;
        tick();
        @(negedge clk);
        bus_if.bus_ready = 1'b1;
        bus_if.bus_rdata = 32'h88;
        bus_if.flush     = 1'b1;
        tick();
        bus_if.bus_ready = 1'b0;
        bus_if.flush     = 1'b0;
        @(negedge clk);
        total++;
        if ({bus_if.bus_req, bus_if.if_ack} !== 2'b00) begin
            bad++;
            $display("FAIL flush_edge got=%b exp=00", {bus_if.bus_req, bus_if.if_ack});
        end
        tick();
        bus_if.if_req = 1'b0;
        bus_if.mem_req  = 1'b1;
        bus_if.mem_addr = 32'h600;
        tick();
        bus_if.flush     = 1'b1;
        bus_if.bus_ready = 1'b1;
        bus_if.bus_rdata = 32'h66;
        tick();
        bus_if.flush     = 1'b0;
        bus_if.bus_ready = 1'b0;
        @(negedge clk);
        total++;
        if ({bus_if.mem_ack, bus_if.mem_rdata} !== {1'b1, 32'h66}) begin
            bad++;
            $display("FAIL flush_mem_unaffected got=%h exp=%h", {bus_if.mem_ack, bus_if.mem_rdata}, {1'b1, 32'h66});
        end
        tick();
        bus_if.mem_req = 1'b0;
    endtask

    task automatic test_timeout();
        int n;
        n = 0;
        do_reset();
`ifdef MEM_ARB_TIMEOUT_EN
        bus_if.if_req  = 1'b1;
        bus_if.if_addr = 32'h500;
        tick();
        @(negedge clk);
        bus_if.bus_ready = 1'b1;
        bus_if.bus_rdata = 32'hABCD;
        tick();
        bus_if.bus_ready = 1'b0;
        @(negedge clk);
        total++;
        if ({bus_if.if_ack, bus_if.if_rdata, bus_if.err_timeout} !== {1'b1, 32'hABCD, 1'b0}) begin
            bad++;
            $display("FAIL timeout_pre_fetch got=%h exp=%h", {bus_if.if_ack, bus_if.if_rdata, bus_if.err_timeout},
                     {1'b1, 32'hABCD, 1'b0});
        end
        tick();
        bus_if.if_req = 1'b0;
        tick();
        bus_if.if_req  = 1'b1;
        bus_if.if_addr = 32'h504;
        tick();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (!bus_if.bus_req) break;
            n++;
        end
        total++;
        if (n != 4) begin
            bad++;
            $display("FAIL timeout_busy_cycles got=%0d exp=4", n);
        end
        total++;
        if ({bus_if.if_ack, bus_if.if_rdata, bus_if.err_timeout} !== {1'b1, 32'h0, 1'b1}) begin
            bad++;
            $display("FAIL timeout_ack got=%h exp=%h", {bus_if.if_ack, bus_if.if_rdata, bus_if.err_timeout},
                     {1'b1, 32'h0, 1'b1});
        end
        tick();
        bus_if.if_req = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (bus_if.err_timeout !== 1'b1) begin
            bad++;
            $display("FAIL timeout_sticky got=%b exp=1", bus_if.err_timeout);
        end
        tick();
        rstn = 1'b0;
        #1;
        total++;
        if (bus_if.err_timeout !== 1'b0) begin
            bad++;
            $display("FAIL timeout_reset_clear got=%b exp=0", bus_if.err_timeout);
        end
        tick();
        rstn = 1'b1;
`else
        bus_if.if_req  = 1'b1;
        bus_if.if_addr = 32'h500;
        tick();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus_if.bus_req && !bus_if.err_timeout) n++;
        end
        total++;
        if (n != 20) begin
            bad++;
            $display("FAIL wait_unbounded got=%0d exp=20", n);
        end
        bus_if.bus_ready = 1'b1;
        bus_if.bus_rdata = 32'h1234;
        tick();
        bus_if.bus_ready = 1'b0;
        @(negedge clk);
        total++;
        if ({bus_if.if_ack, bus_if.if_rdata, bus_if.err_timeout} !== {1'b1, 32'h1234, 1'b0}) begin
            bad++;
            $display("FAIL wait_late_ack got=%h exp=%h", {bus_if.if_ack, bus_if.if_rdata, bus_if.err_timeout},
                     {1'b1, 32'h1234, 1'b0});
        end
        tick();
        bus_if.if_req = 1'b0;
`endif
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus_if.mem_req  = 1'b1;
        bus_if.mem_addr = 32'h40;
        tick();
        @(negedge clk);
        bus_if.bus_ready = 1'b1;
        bus_if.bus_rdata = 32'h99;
        tick();
        bus_if.bus_ready = 1'b0;
        @(negedge clk);
        total++;
        if ({bus_if.mem_ack, bus_if.mem_rdata} !== {1'b1, 32'h99}) begin
            bad++;
            $display("FAIL rst_mid_load got=%h exp=%h", {bus_if.mem_ack, bus_if.mem_rdata}, {1'b1, 32'h99});
        end
        tick();
        bus_if.mem_req = 1'b0;
        tick();
        bus_if.mem_req   = 1'b1;
        bus_if.mem_we    = 1'b1;
        bus_if.mem_addr  = 32'h44;
        bus_if.mem_wdata = 32'h1234;
        bus_if.mem_wstrb = 4'hF;
        tick();
        @(negedge clk);
        total++;
        if (bus_if.bus_req !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_busy got=%b exp=1", bus_if.bus_req);
        end
        tick();
        rstn = 1'b0;
        #1;
        total++;
        if (all_outs() !== 137'h0) begin
            bad++;
            $display("FAIL rst_mid_immediate got=%h exp=0", all_outs());
        end
        clear_inputs();
        tick();
        rstn = 1'b1;
        bus_if.bus_ready = 1'b1;
        bus_if.bus_rdata = 32'hEE;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (all_outs() !== 137'h0) begin
                bad++;
                $display("FAIL rst_mid_late_ready c=%0d got=%h exp=0", c, all_outs());
            end
            tick();
        end
        bus_if.bus_ready = 1'b0;
    endtask

    task automatic test_random();
        logic        last_mem, pend_if, pend_mem, win_mem, p_we;
        logic [31:0] p_if_addr, p_mem_addr, p_wdata, exp_if_rd, exp_mem_rd, rd;
        logic [3:0]  p_wstrb;
        logic [69:0] exp_bus;
        int          lat;
        do_reset();
        last_mem   = 1'b0;
        pend_if    = 1'b0;
        pend_mem   = 1'b0;
        p_we       = 1'b0;
        p_if_addr  = 32'h0;
        p_mem_addr = 32'h0;
        p_wdata    = 32'h0;
        p_wstrb    = 4'h0;
        exp_if_rd  = 32'h0;
        exp_mem_rd = 32'h0;
        for (int it = 0; it < 80; it++) begin
            if (!pend_if && $urandom_range(0, 1) == 1) begin
                pend_if        = 1'b1;
                p_if_addr      = $urandom;
                bus_if.if_req  = 1'b1;
                bus_if.if_addr = p_if_addr;
            end
            if (!pend_mem && $urandom_range(0, 1) == 1) begin
                pend_mem         = 1'b1;
                p_we             = 1'($urandom_range(0, 1));
                p_mem_addr       = $urandom;
                p_wdata          = $urandom;
                p_wstrb          = 4'($urandom_range(0, 15));
                bus_if.mem_req   = 1'b1;
                bus_if.mem_we    = p_we;
                bus_if.mem_addr  = p_mem_addr;
                bus_if.mem_wdata = p_wdata;
                bus_if.mem_wstrb = p_wstrb;
            end
            if (!pend_if && !pend_mem) begin
                @(negedge clk);
                total++;
                if (bus_if.bus_req !== 1'b0) begin
                    bad++;
                    $display("FAIL rand_idle it=%0d got=%b exp=0", it, bus_if.bus_req);
                end
                tick();
                continue;
            end
            win_mem = pend_mem && !(last_mem && pend_if);
            exp_bus = win_mem ? {1'b1, p_we, p_mem_addr, p_wdata, p_wstrb}
                              : {1'b1, 1'b0, p_if_addr, 32'h0, 4'h0};
            lat = $urandom_range(0, 3);
            tick();
            for (int l = 0; l <= lat; l++) begin
                @(negedge clk);
                total++;
                if ({bus_vec(), bus_if.stall_if, bus_if.stall_mem, bus_if.if_ack, bus_if.mem_ack} !==
                    {exp_bus, pend_if, pend_mem, 2'b00}) begin
                    bad++;
                    $display("FAIL rand_busy it=%0d got=%h exp=%h", it,
                             {bus_vec(), bus_if.stall_if, bus_if.stall_mem, bus_if.if_ack, bus_if.mem_ack},
                             {exp_bus, pend_if, pend_mem, 2'b00});
                end
                if (l < lat) tick();
            end
            rd = $urandom;
            bus_if.bus_ready = 1'b1;
            bus_if.bus_rdata = rd;
            tick();
            bus_if.bus_ready = 1'b0;
            if (win_mem) exp_mem_rd = rd;
            else         exp_if_rd  = rd;
            @(negedge clk);
            total++;
            if ({bus_if.bus_req, bus_if.if_ack, bus_if.mem_ack, bus_if.stall_if, bus_if.stall_mem,
                 bus_if.if_rdata, bus_if.mem_rdata} !==
                {1'b0, !win_mem, win_mem, pend_if && win_mem, pend_mem && !win_mem, exp_if_rd, exp_mem_rd}) begin
                bad++;
                $display("FAIL rand_done it=%0d got=%h exp=%h", it,
                         {bus_if.bus_req, bus_if.if_ack, bus_if.mem_ack, bus_if.stall_if, bus_if.stall_mem,
                          bus_if.if_rdata, bus_if.mem_rdata},
                         {1'b0, !win_mem, win_mem, pend_if && win_mem, pend_mem && !win_mem, exp_if_rd, exp_mem_rd});
            end
            last_mem = win_mem;
            tick();
            if (win_mem) begin
                bus_if.mem_req = 1'b0;
                pend_mem       = 1'b0;
            end else begin
                bus_if.if_req = 1'b0;
                pend_if       = 1'b0;
            end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_contention();
        test_store();
        test_flush();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
